// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Sequences the 5-stage pipeline around the decode control unit. Sits in ID
// beside the control unit and the control-word mux. It tracks the destination
// registers of the instructions in EX/MEM/WB. From those it computes the
// operand forwarding selects. It also detects load-use and CC-use hazards.
// Finally it drives the NOP-injection select, the PC/nPC/IF-ID load enables
// and the delay-slot annul.
//
// Handshake: there is no valid/ready pair. The block reacts to whatever
// instruction sits in ID on every cycle.
//   - pc_le/ifid_le low means the front end holds ID steady.
//   - cw_zero high means the instruction in ID does not advance into EX; a
//     bubble goes into EX instead.
//
// Ports
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   id_rs1/id_rs2/id_rd   register addresses of the instruction in ID
//   id_use_rs1/id_use_rs2 ID reads rs1 / rs2
//   id_store              ID reads rd as store data
//   id_rf_we, id_load     ID writes rd / is a load
//   id_cc_we              ID modifies condition codes
//   id_branch, id_br_taken, id_br_always, id_annul   Bicc decode
//   cw_zero               1 = inject all-zero control word into EX
//   pc_le, ifid_le        PC/nPC and IF/ID load enables
//   ifid_clr              IF/ID loads an all-zero instruction (annul)
//   fwd_a/fwd_b/fwd_c     rs1/rs2/rd selects: 00 RF, 01 EX, 10 MEM, 11 WB
//   stall_cnt             hazard stall cycles since reset, saturating
//   dbg_state             current FSM state (0 HOLD, 1 RUN, 2 STALL)
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int RA_W        = 5,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_store,
  input  logic             id_rf_we,
  input  logic             id_load,
  input  logic             id_cc_we,
  input  logic             id_branch,
  input  logic             id_br_taken,
  input  logic             id_br_always,
  input  logic             id_annul,
  output logic             cw_zero,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt, hold_nxt;

  // Destination tracking. Only EX needs load/cc_we; the later stages only
  // feed forwarding, so they carry just rd and the write enable.
  logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;
  logic            ex_we, mem_we, wb_we;
  logic            ex_load, ex_cc_we;

  logic load_use, cc_use, hazard, count_stall;

  // First match wins, youngest producer first.
  function automatic logic [1:0] fwd_sel(
    input logic            use_src,
    input logic [RA_W-1:0] src,
    input logic            e_we,
    input logic [RA_W-1:0] e_rd,
    input logic            m_we,
    input logic [RA_W-1:0] m_rd,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && (src != '0)) begin
      if (e_we && (e_rd == src))      sel = 2'b01;
      else if (m_we && (m_rd == src)) sel = 2'b10;
      else if (w_we && (w_rd == src)) sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(id_use_rs1, id_rs1, ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
    fwd_b = fwd_sel(id_use_rs2, id_rs2, ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
    fwd_c = fwd_sel(id_store,   id_rd,  ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
  end

  // A load in EX has no data yet, so any reader in ID must wait one cycle.
  // Once the load reaches MEM, the MEM path covers the value.
  always_comb begin
    load_use = ex_load && ex_we && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)) ||
                (id_store   && (id_rd  == ex_rd)));
    cc_use   = id_branch && ex_cc_we;
    hazard   = load_use || cc_use;
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    cw_zero     = 1'b1;
    pc_le       = 1'b0;
    ifid_le     = 1'b0;
    ifid_clr    = 1'b0;
    count_stall = 1'b0;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
        else                       hold_nxt  = hold_cnt + 1'b1;
      end
      ST_RUN, ST_STALL: begin
        if (hazard) begin
          // Freeze the front end and bubble EX. A branch is left unresolved
          // until the hazard has cleared.
          state_nxt   = ST_STALL;
          count_stall = 1'b1;
        end else begin
          state_nxt = ST_RUN;
          cw_zero   = 1'b0;
          pc_le     = 1'b1;
          ifid_le   = 1'b1;
          // Annulled branch: the delay slot is squashed unless the branch is
          // a conditional that is taken.
          ifid_clr  = id_branch && id_annul && (!id_br_taken || id_br_always);
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      ex_cc_we  <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      ex_rd    <= cw_zero ? '0 : id_rd;
      ex_we    <= id_rf_we && !cw_zero;
      ex_load  <= id_load  && !cw_zero;
      ex_cc_we <= id_cc_we && !cw_zero;
      mem_rd   <= ex_rd;
      mem_we   <= ex_we;
      wb_rd    <= mem_rd;
      wb_we    <= mem_we;
      if (count_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int RA_W  = 5;
  localparam int HOLD  = 2;
  localparam int CNT_W = 6;
  localparam int W     = 10 + CNT_W;

  typedef struct packed {
    logic            rst_n;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            use1, use2, store, we, load, cc, br, tk, ba, an;
  } in_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            we, load, cc;
  } stage_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic [RA_W-1:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic             id_use_rs1 = 0, id_use_rs2 = 0, id_store = 0, id_rf_we = 0;
  logic             id_load = 0, id_cc_we = 0, id_branch = 0, id_br_taken = 0;
  logic             id_br_always = 0, id_annul = 0;
  logic             cw_zero, pc_le, ifid_le, ifid_clr;
  logic [1:0]       fwd_a, fwd_b, fwd_c, dbg_state;
  logic [CNT_W-1:0] stall_cnt;

  pipeline_hazard_controller #(.RA_W(RA_W), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_store(id_store),
    .id_rf_we(id_rf_we), .id_load(id_load), .id_cc_we(id_cc_we),
    .id_branch(id_branch), .id_br_taken(id_br_taken), .id_br_always(id_br_always),
    .id_annul(id_annul),
    .cw_zero(cw_zero), .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clr(ifid_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // The pipeline is modelled as a list of the last three issued slots
  // (index 0 = EX), plus the number of start-up cycles still to go.
  stage_t m_pipe[$];
  int     m_hold;
  int     m_cnt;
  bit     m_known = 0;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic logic [1:0] m_fwd(input logic use_src, input logic [RA_W-1:0] src);
    if (!use_src || src == 0) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (m_pipe[k].we && m_pipe[k].rd == src) return 2'(k + 1);
    return 2'b00;
  endfunction

  task automatic m_reset();
    m_pipe.delete();
    for (int k = 0; k < 3; k++) m_pipe.push_back('0);
    m_hold = HOLD;
    m_cnt  = 0;
    m_known = 1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t x);
    logic cw, pc, clr, haz;
    logic [W-1:0] e;
    stage_t ns;
    @(posedge clk); #1;
    reset_n = x.rst_n;
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
    id_use_rs1 = x.use1; id_use_rs2 = x.use2; id_store = x.store;
    id_rf_we = x.we; id_load = x.load; id_cc_we = x.cc;
    id_branch = x.br; id_br_taken = x.tk; id_br_always = x.ba; id_annul = x.an;
    cyc++;
    if (m_known) begin
      haz = 0;
      if (m_hold > 0) begin
        cw = 1; pc = 0; clr = 0;
      end else begin
        haz = (m_pipe[0].load && m_pipe[0].we && m_pipe[0].rd != 0 &&
               ((x.use1 && x.rs1 == m_pipe[0].rd) || (x.use2 && x.rs2 == m_pipe[0].rd) ||
                (x.store && x.rd == m_pipe[0].rd))) || (x.br && m_pipe[0].cc);
        cw  = haz;
        pc  = !haz;
        clr = !haz && x.br && x.an && (!x.tk || x.ba);
      end
      e = {cw, pc, pc, clr, m_fwd(x.use1, x.rs1), m_fwd(x.use2, x.rs2),
           m_fwd(x.store, x.rd), CNT_W'(m_cnt)};
      exp_q.push_back(e);
      // effect of the coming clock edge
      if (!x.rst_n) m_reset();
      else begin
        ns = cw ? stage_t'('0) : stage_t'({x.rd, x.we, x.load, x.cc});
        void'(m_pipe.pop_back());
        m_pipe.push_front(ns);
        if (m_hold > 0) m_hold--;
        if (haz && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end else if (!x.rst_n) m_reset();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {cw_zero, pc_le, ifid_le, ifid_clr, fwd_a, fwd_b, fwd_c, stall_cnt};
      n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle%0d outputs {cw,pc,ifid,clr,fa,fb,fc,cnt}: got %b_%b_%b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%b_%b_%0d",
                 cyc, act[W-1], act[W-2], act[W-3], act[W-4], act[W-5:W-6], act[W-7:W-8],
                 act[W-9:W-10], act[CNT_W-1:0], e[W-1], e[W-2], e[W-3], e[W-4],
                 e[W-5:W-6], e[W-7:W-8], e[W-9:W-10], e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- instruction builders ----------------
  function automatic in_t f_nop();
    in_t x = '0;
    x.rst_n = 1;
    return x;
  endfunction

  function automatic in_t f_alu(input int rd, input int rs1, input int rs2, input bit cc);
    in_t x = f_nop();
    x.rd = RA_W'(rd); x.rs1 = RA_W'(rs1); x.rs2 = RA_W'(rs2);
    x.use1 = 1; x.use2 = 1; x.we = 1; x.cc = cc;
    return x;
  endfunction

  function automatic in_t f_ld(input int rd, input int rs1);
    in_t x = f_nop();
    x.rd = RA_W'(rd); x.rs1 = RA_W'(rs1); x.use1 = 1; x.we = 1; x.load = 1;
    return x;
  endfunction

  function automatic in_t f_br(input bit tk, input bit ba, input bit an);
    in_t x = f_nop();
    x.br = 1; x.tk = tk; x.ba = ba; x.an = an;
    return x;
  endfunction

  function automatic in_t f_rand(input bit allow_rst);
    in_t x;
    x.rst_n = !(allow_rst && $urandom_range(0, 149) == 0);
    x.rs1 = RA_W'($urandom_range(0, 7));
    x.rs2 = RA_W'($urandom_range(0, 7));
    x.rd  = RA_W'($urandom_range(0, 7));
    x.use1 = $urandom_range(0, 3) != 0;
    x.use2 = $urandom_range(0, 1);
    x.load = $urandom_range(0, 3) == 0;
    x.we   = x.load || ($urandom_range(0, 2) != 0);
    x.store = !x.we && ($urandom_range(0, 1) == 1);
    x.cc = $urandom_range(0, 3) == 0;
    x.br = $urandom_range(0, 3) == 0;
    x.tk = $urandom_range(0, 1);
    x.ba = $urandom_range(0, 3) == 0;
    x.an = $urandom_range(0, 1);
    return x;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    in_t r;
    r = f_nop(); r.rst_n = 0;
    repeat (3) drive(r);
    repeat (4) drive(f_nop());            // two frozen cycles, then running

    drive(f_ld(5, 1));                    // ld r5
    drive(f_alu(6, 5, 7, 0));             // add r6,r5,r7: stalls
    drive(f_alu(6, 5, 7, 0));             // reissued: forwards from MEM
    drive(f_alu(3, 1, 2, 0));             // add r3
    drive(f_alu(4, 3, 3, 0));             // sub r4,r3,r3: EX forward on both
    drive(f_alu(0, 1, 2, 0));             // writes r0
    drive(f_alu(8, 0, 0, 0));             // reads r0: never forwarded
    drive(f_alu(9, 1, 2, 1));             // subcc
    drive(f_br(0, 0, 1));                 // bne,a not taken: stalls
    drive(f_br(0, 0, 1));                 // then annuls
    drive(f_br(1, 1, 1));                 // ba,a
    drive(f_br(1, 0, 1));                 // be,a taken
    drive(f_ld(5, 2));
    r = f_alu(6, 5, 5, 0); r.rst_n = 0;   // reset during the stall
    drive(r);
    drive(f_alu(7, 5, 5, 0));
    repeat (3) drive(f_nop());

    // Repeated load-use pairs drive the stall counter into saturation.
    for (int i = 0; i < 70; i++) begin
      drive(f_ld(5, 1));
      r = f_nop(); r.rd = 5; r.store = 1;
      drive(r);
    end
    repeat (3) drive(f_nop());

    for (int i = 0; i < 2500; i++) drive(f_rand(i > 1200));

    @(posedge clk); @(negedge clk); @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
